// File: rtl/sequenciador_autenticacao.sv
// Authentication sequencer: synchronises the ENTER button, checks a 3-bit switch code
// against SECRET, counts consecutive failures and enforces a timed lockout.
module sequenciador_autenticacao #(
  parameter logic [2:0] SECRET      = 3'b101,
  parameter int         MAX_TRIES   = 3,
  parameter int         SHOW_CYCLES = 100,
  parameter int         LOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] code_in,
  input  logic       enter,
  output logic [6:0] seg,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic [1:0] tries_left
);

  localparam int MAXC = (LOCK_CYCLES > SHOW_CYCLES) ? LOCK_CYCLES : SHOW_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    MAX_T     = 2'(MAX_TRIES);

  localparam logic [6:0] SEG_IDLE = 7'b0000001;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_E    = 7'b1001111;
  localparam logic [6:0] SEG_L    = 7'b0001110;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_GRANTED = 3'd2,
    ST_DENIED  = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nx;
  logic [1:0]     r_fail;
  logic [1:0]     w_fail_nx;
  logic [TW-1:0]  r_timer;
  logic [TW-1:0]  w_timer_nx;
  logic [2:0]     r_code;
  logic           w_capture;
  logic           r_s1;
  logic           r_s2;
  logic           r_s3;
  logic           w_enter_pulse;
  logic [6:0]     r_seg;
  logic           r_granted;
  logic           r_denied;
  logic           r_locked;
  logic [1:0]     r_tries_left;

  function automatic logic [6:0] seg_for(input state_t st);
    case (st)
      ST_GRANTED: return SEG_A;
      ST_DENIED:  return SEG_E;
      ST_LOCKOUT: return SEG_L;
      default:    return SEG_IDLE;
    endcase
  endfunction

  // ENTER conditioning: two-flop synchroniser plus rising-edge detector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= enter;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_enter_pulse = r_s2 & ~r_s3;

  // Captured code is pure data, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_capture) r_code <= code_in;
  end

  always_comb begin
    w_state_nx = r_state;
    w_fail_nx  = r_fail;
    w_timer_nx = '0;
    w_capture  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_enter_pulse) begin
          w_capture  = 1'b1;
          w_state_nx = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_code == SECRET) begin
          w_fail_nx  = 2'd0;
          w_state_nx = ST_GRANTED;
        end else if (int'(r_fail) + 1 == MAX_TRIES) begin
          w_fail_nx  = MAX_T;
          w_state_nx = ST_LOCKOUT;
        end else begin
          w_fail_nx  = r_fail + 2'd1;
          w_state_nx = ST_DENIED;
        end
      end
      ST_GRANTED, ST_DENIED: begin
        if (r_timer == SHOW_LAST) w_state_nx = ST_IDLE;
        else                      w_timer_nx = r_timer + TW'(1);
      end
      ST_LOCKOUT: begin
        if (r_timer == LOCK_LAST) begin
          w_state_nx = ST_IDLE;
          w_fail_nx  = 2'd0;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_fail  <= 2'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nx;
      r_fail  <= w_fail_nx;
      r_timer <= w_timer_nx;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg        <= SEG_IDLE;
      r_granted    <= 1'b0;
      r_denied     <= 1'b0;
      r_locked     <= 1'b0;
      r_tries_left <= MAX_T;
    end else begin
      r_seg        <= seg_for(w_state_nx);
      r_granted    <= (w_state_nx == ST_GRANTED);
      r_denied     <= (w_state_nx == ST_DENIED);
      r_locked     <= (w_state_nx == ST_LOCKOUT);
      r_tries_left <= MAX_T - w_fail_nx;
    end
  end

  assign seg        = r_seg;
  assign granted    = r_granted;
  assign denied     = r_denied;
  assign locked     = r_locked;
  assign tries_left = r_tries_left;

endmodule

// File: tb/tb_sequenciador_autenticacao.sv
// Scoreboard bench for sequenciador_autenticacao: stimulus queues expected result
// episodes, a monitor matches each GRANTED/DENIED/LOCKOUT episode as it appears.
module tb_sequenciador_autenticacao;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] code_in;
  logic       enter;
  logic [6:0] seg;
  logic       granted;
  logic       denied;
  logic       locked;
  logic [1:0] tries_left;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] flags;
    logic [6:0] seg;
    int         dur;
    logic [1:0] tl_during;
    logic [1:0] tl_after;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sequenciador_autenticacao #(
    .SECRET      (3'b101),
    .MAX_TRIES   (3),
    .SHOW_CYCLES (4),
    .LOCK_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .code_in    (code_in),
    .enter      (enter),
    .seg        (seg),
    .granted    (granted),
    .denied     (denied),
    .locked     (locked),
    .tries_left (tries_left)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"},   32'(seg), 32'(7'b0000001));
    check({tag, "_flags"}, 32'({granted, denied, locked}), 32'(3'b000));
    check({tag, "_tries"}, 32'(tries_left), 32'd3);
  endtask

  task automatic exp_g();
    sb.push_back('{3'b100, 7'b1110111, 4, 2'd3, 2'd3});
  endtask

  task automatic exp_d(input logic [1:0] tl);
    sb.push_back('{3'b010, 7'b1001111, 4, tl, tl});
  endtask

  task automatic exp_l(input int dur);
    sb.push_back('{3'b001, 7'b0001110, dur, 2'd0, 2'd3});
  endtask

  task automatic press(input logic [2:0] c, input int hold, input int idle);
    @(negedge clk);
    code_in = c;
    enter   = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic press2(input logic [2:0] c, input int h1, input int gap, input int h2,
                        input int idle);
    @(negedge clk);
    code_in = c;
    enter   = 1'b1;
    repeat (h1) @(negedge clk);
    enter = 1'b0;
    repeat (gap) @(negedge clk);
    enter = 1'b1;
    repeat (h2) @(negedge clk);
    enter = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  // Monitor: one scoreboard entry per result episode
  initial begin
    exp_t e;
    int   cnt;
    bit   have;
    forever begin
      @(negedge clk);
      if ({granted, denied, locked} != 3'b000) begin
        have = (sb.size() != 0);
        if (have) begin
          e = sb.pop_front();
          check("ep_flags", 32'({granted, denied, locked}), 32'(e.flags));
          check("ep_seg",   32'(seg), 32'(e.seg));
          check("ep_tries", 32'(tries_left), 32'(e.tl_during));
        end else begin
          checks++;
          failures++;
          $display("FAIL unexpected_episode flags=%b expected=none", {granted, denied, locked});
        end
        cnt = 1;
        while (cnt < 200) begin
          @(negedge clk);
          if ({granted, denied, locked} == 3'b000) break;
          cnt++;
        end
        if (have) begin
          check("ep_duration",   32'(cnt), 32'(e.dur));
          check("post_seg",      32'(seg), 32'(7'b0000001));
          check("post_tries",    32'(tries_left), 32'(e.tl_after));
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    enter   = 1'b0;
    code_in = 3'b000;
    #1 reset = 1'b1;
    #2 check_reset_vals("reset0");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("idle0");

    // Correct code, enter held 5 cycles
    exp_g();
    press(3'b101, 5, 12);
    // Single wrong press
    exp_d(2'd2);
    press(3'b011, 1, 12);
    // Clear, then three wrong presses: third locks without DENIED
    exp_g();
    press(3'b101, 1, 12);
    exp_d(2'd2);
    press(3'b011, 1, 12);
    exp_d(2'd1);
    press(3'b000, 1, 12);
    exp_l(10);
    press(3'b111, 1, 18);
    // Grant clears partial failures; two more misses must not lock
    exp_d(2'd2);
    press(3'b001, 1, 12);
    exp_d(2'd1);
    press(3'b100, 1, 12);
    exp_g();
    press(3'b101, 1, 12);
    exp_d(2'd2);
    press(3'b001, 1, 12);
    exp_d(2'd1);
    press(3'b110, 1, 12);
    exp_g();
    press(3'b101, 1, 12);
    // Second press lands during GRANTED, then on the GRANTED->IDLE edge
    exp_g();
    press2(3'b101, 1, 2, 1, 12);
    exp_g();
    press2(3'b101, 1, 4, 1, 12);
    // Second press lands during LOCKOUT
    exp_d(2'd2);
    press(3'b000, 1, 12);
    exp_d(2'd1);
    press(3'b110, 1, 12);
    exp_l(10);
    press2(3'b000, 1, 3, 1, 18);
    // Enter held well past the return to IDLE
    exp_g();
    press(3'b101, 20, 12);
    // Reset in the fifth LOCKOUT cycle
    exp_d(2'd2);
    press(3'b011, 1, 12);
    exp_d(2'd1);
    press(3'b011, 1, 12);
    exp_l(5);
    @(negedge clk);
    code_in = 3'b011;
    enter   = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_vals("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_g();
    press(3'b101, 2, 12);

    repeat (20) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
